// File: rtl/calypto_mem_mp_pm.sv
// Multi-port synchronous memory with bit write masks, per-bit write-write arbitration,
// 1- or 2-cycle read latency and an ACTIVE/LSLEEP/DSLEEP/SHUTDOWN/WAKE power-state FSM.
module calypto_mem_mp_pm #(
    parameter int AW         = 5,
    parameter int DW         = 8,
    parameter int NRP        = 2,
    parameter int NWP        = 2,
    parameter int WT         = 0,
    parameter int RD_LAT     = 1,
    parameter int WAKE_CYC   = 4,
    parameter int DS_SD_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRP-1:0]    re,
    input  logic [NRP*AW-1:0] radr,
    output logic [NRP*DW-1:0] q,
    output logic [NRP-1:0]    qv,
    input  logic [NWP-1:0]    we,
    input  logic [NWP*AW-1:0] wadr,
    input  logic [NWP*DW-1:0] d,
    input  logic [NWP*DW-1:0] wm,
    input  logic              ls,
    input  logic              ds,
    input  logic              sd,
    output logic              rdy,
    output logic [NWP-1:0]    wconf,
    output logic              drop
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYC - 1);

    typedef enum logic [2:0] {
        ST_ACTIVE,
        ST_LSLEEP,
        ST_DSLEEP,
        ST_SHUTDOWN,
        ST_WAKE
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           acc_en;
    logic           keep_valid;
    logic           dark;
    logic           enter_sd;

    // Flattened ports viewed as per-port packed elements (same bit layout).
    logic [NWP-1:0][AW-1:0] wa;
    logic [NWP-1:0][DW-1:0] wd;
    logic [NWP-1:0][DW-1:0] wmk;
    logic [NRP-1:0][AW-1:0] ra;

    assign wa  = wadr;
    assign wd  = d;
    assign wmk = wm;
    assign ra  = radr;

    // ---------------- power-state FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACTIVE: begin
                if (sd)      state_d = ST_SHUTDOWN;
                else if (ds) state_d = ST_DSLEEP;
                else if (ls) state_d = ST_LSLEEP;
            end
            ST_LSLEEP: begin
                if (sd)       state_d = ST_SHUTDOWN;
                else if (ds)  state_d = ST_DSLEEP;
                else if (!ls) state_d = ST_ACTIVE;
            end
            ST_DSLEEP: begin
                if (sd) begin
                    state_d = ST_SHUTDOWN;
                end else if (!ds) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            ST_SHUTDOWN: begin
                if (!sd) begin
                    if (ds) begin
                        state_d = ST_DSLEEP;
                    end else begin
                        state_d = ST_WAKE;
                        cnt_d   = WAKE_LOAD;
                    end
                end
            end
            ST_WAKE: begin
                if (sd) begin
                    state_d = ST_SHUTDOWN;
                    cnt_d   = '0;
                end else if (ds) begin
                    state_d = ST_DSLEEP;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_comb begin
        rdy        = (state_q == ST_ACTIVE);
        acc_en     = rdy && !rst;
        // Read data is only ever delivered into an ACTIVE cycle; anything that would land later is flushed.
        keep_valid = (state_d == ST_ACTIVE) && !rst;
        dark       = (state_q == ST_DSLEEP) || (state_q == ST_SHUTDOWN) || (state_q == ST_WAKE);
        enter_sd   = (state_d == ST_SHUTDOWN) && (state_q != ST_SHUTDOWN) && !rst;
    end

    // ---------------- write arbitration ----------------
    logic [DEPTH-1:0][DW-1:0] mem;
    logic [NWP-1:0][DW-1:0]   wen;
    logic [NWP-1:0][DW-1:0]   wword;
    logic [NWP-1:0]           wconf_d;

    // NOTE: combinational blocks use blocking '=' so later statements see the updated value;
    // clocked blocks use '<=' only.
    always_comb begin
        logic [DW-1:0] claimed;
        logic [DW-1:0] w;
        for (int p = 0; p < NWP; p++) begin
            wen[p] = (acc_en && we[p]) ? ~wmk[p] : '0;
        end
        for (int p = 0; p < NWP; p++) begin
            claimed = '0;
            for (int j = 0; j < p; j++) begin
                if (wa[j] == wa[p]) claimed = claimed | wen[j];
            end
            wconf_d[p] = |(wen[p] & claimed);
            // Apply ports highest index first so the lowest index owns any overlapping bit.
            w = mem[wa[p]];
            for (int j = NWP - 1; j >= 0; j--) begin
                if (wa[j] == wa[p]) w = (w & ~wen[j]) | (wd[j] & wen[j]);
            end
            wword[p] = w;
        end
    end

    // NOTE: the storage array has no reset; contents survive rst by design.
    for (genvar a = 0; a < DEPTH; a++) begin : g_word
        logic [DW-1:0] word_q;
        logic          hit;
        logic [DW-1:0] nxt;

        always_comb begin
            hit = 1'b0;
            nxt = word_q;
            for (int p = 0; p < NWP; p++) begin
                if ((|wen[p]) && (wa[p] == AW'(a))) begin
                    hit = 1'b1;
                    nxt = wword[p];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (enter_sd)  word_q <= 'x;
            else if (hit)  word_q <= nxt;
        end

        assign mem[a] = word_q;
    end

    // ---------------- read path ----------------
    logic [NRP-1:0][DW-1:0] rword;

    always_comb begin
        logic [DW-1:0] w;
        for (int i = 0; i < NRP; i++) begin
            w = mem[ra[i]];
            if (WT != 0) begin
                for (int j = NWP - 1; j >= 0; j--) begin
                    if (wa[j] == ra[i]) w = (w & ~wen[j]) | (wd[j] & wen[j]);
                end
            end
            rword[i] = w;
        end
    end

    logic [NRP-1:0]         v1_q;
    logic [NRP-1:0][DW-1:0] q1_q;
    logic [NRP-1:0]         v_out;
    logic [NRP-1:0][DW-1:0] q_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= '0;
            q1_q <= '0;
        end else begin
            for (int i = 0; i < NRP; i++) begin
                v1_q[i] <= acc_en && re[i] && keep_valid;
                if (acc_en && re[i] && keep_valid) q1_q[i] <= rword[i];
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [NRP-1:0]         v2_q;
        logic [NRP-1:0][DW-1:0] q2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                v2_q <= '0;
                q2_q <= '0;
            end else begin
                for (int i = 0; i < NRP; i++) begin
                    v2_q[i] <= v1_q[i] && keep_valid;
                    if (v1_q[i] && keep_valid) q2_q[i] <= q1_q[i];
                end
            end
        end

        assign v_out = v2_q;
        assign q_out = q2_q;
    end else begin : g_lat1
        assign v_out = v1_q;
        assign q_out = q1_q;
    end

    assign qv = v_out;
    assign q  = dark ? ((DS_SD_ZERO != 0) ? '0 : 'x) : q_out;

    // ---------------- status pulses ----------------
    logic [NWP-1:0] wconf_q;
    logic           drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wconf_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            wconf_q <= wconf_d;
            drop_q  <= !rdy && ((|re) || (|we));
        end
    end

    assign wconf = wconf_q;
    assign drop  = drop_q;

endmodule

// File: tb/tb_calypto_mem_mp_pm.sv
// Directed bench: instance a (WT=0, RD_LAT=1) and instance b (WT=1, RD_LAT=2) share all stimulus.
module tb_calypto_mem_mp_pm;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  re, we;
    logic [9:0]  radr, wadr;
    logic [15:0] d, wm;
    logic        ls, ds, sd;

    logic [15:0] q_a, q_b;
    logic [1:0]  qv_a, qv_b, wconf_a, wconf_b;
    logic        rdy_a, rdy_b, drop_a, drop_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calypto_mem_mp_pm #(.WT(0), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .re(re), .radr(radr), .q(q_a), .qv(qv_a),
        .we(we), .wadr(wadr), .d(d), .wm(wm), .ls(ls), .ds(ds), .sd(sd),
        .rdy(rdy_a), .wconf(wconf_a), .drop(drop_a)
    );

    calypto_mem_mp_pm #(.WT(1), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .re(re), .radr(radr), .q(q_b), .qv(qv_b),
        .we(we), .wadr(wadr), .d(d), .wm(wm), .ls(ls), .ds(ds), .sd(sd),
        .rdy(rdy_b), .wconf(wconf_b), .drop(drop_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        re   = '0;
        we   = '0;
        radr = '0;
        wadr = '0;
        d    = '0;
        wm   = '0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [7:0] dd, input logic [7:0] m);
        we[p]           = 1'b1;
        wadr[p*5 +: 5]  = a;
        d[p*8 +: 8]     = dd;
        wm[p*8 +: 8]    = m;
    endtask

    task automatic rd_check(input string tag, input int p, input logic [4:0] a, input logic [7:0] exp);
        logic [1:0] pm;
        pm = 2'b01 << p;
        re             = '0;
        re[p]          = 1'b1;
        radr[p*5 +: 5] = a;
        cyc();
        re = '0;
        check({tag, "_a_q"},  {24'd0, q_a[p*8 +: 8]}, {24'd0, exp});
        check({tag, "_a_qv"}, {30'd0, qv_a}, {30'd0, pm});
        check({tag, "_b_qv0"}, {30'd0, qv_b}, 32'd0);
        cyc();
        check({tag, "_b_q"},  {24'd0, q_b[p*8 +: 8]}, {24'd0, exp});
        check({tag, "_b_qv"}, {30'd0, qv_b}, {30'd0, pm});
        check({tag, "_a_qv0"}, {30'd0, qv_a}, 32'd0);
    endtask

    task automatic check_rdy(input string tag, input logic exp);
        check({tag, "_rdy_a"}, {31'd0, rdy_a}, {31'd0, exp});
        check({tag, "_rdy_b"}, {31'd0, rdy_b}, {31'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        ls = 1'b0; ds = 1'b0; sd = 1'b0;
        idle();
        cyc();
        cyc();
        check_rdy("rst", 1'b1);
        check("rst_qa", {16'd0, q_a}, 32'd0);
        check("rst_qb", {16'd0, q_b}, 32'd0);
        check("rst_qva", {30'd0, qv_a}, 32'd0);
        check("rst_qvb", {30'd0, qv_b}, 32'd0);
        check("rst_wconf", {30'd0, wconf_a}, 32'd0);
        check("rst_drop", {31'd0, drop_a}, 32'd0);
        rst = 1'b0;

        // basic write then read, both ports
        wr(0, 5'd3, 8'hA5, 8'h00); cyc(); idle();
        rd_check("t1", 0, 5'd3, 8'hA5);
        wr(1, 5'd9, 8'h3C, 8'h00); cyc(); idle();
        rd_check("t1p1", 1, 5'd9, 8'h3C);

        // write-write conflicts on word 7
        wr(0, 5'd7, 8'hF0, 8'h0F); wr(1, 5'd7, 8'hFF, 8'h00); cyc(); idle();
        check("t2_wconf_a", {30'd0, wconf_a}, 32'd2);
        check("t2_wconf_b", {30'd0, wconf_b}, 32'd2);
        rd_check("t2a", 1, 5'd7, 8'hFF);
        check("t2_wconf_clr", {30'd0, wconf_a}, 32'd0);
        wr(0, 5'd7, 8'h00, 8'h0F); wr(1, 5'd7, 8'hFF, 8'h00); cyc(); idle();
        check("t2b_wconf", {30'd0, wconf_a}, 32'd2);
        rd_check("t2b", 0, 5'd7, 8'h0F);
        wr(0, 5'd7, 8'hA0, 8'h0F); wr(1, 5'd7, 8'h05, 8'hF0); cyc(); idle();
        check("t2c_disjoint_wconf", {30'd0, wconf_a}, 32'd0);
        rd_check("t2c", 0, 5'd7, 8'hA5);
        wr(0, 5'd7, 8'h3C, 8'h00); wr(1, 5'd7, 8'h00, 8'hFF); cyc(); idle();
        check("t2d_allmask_wconf", {30'd0, wconf_b}, 32'd0);
        rd_check("t2d", 1, 5'd7, 8'h3C);
        wr(1, 5'd7, 8'hFF, 8'hF0); cyc(); idle();
        rd_check("t2e_merge", 0, 5'd7, 8'h3F);
        wr(0, 5'd10, 8'h11, 8'h00); wr(1, 5'd11, 8'h22, 8'h00); cyc(); idle();
        check("t2f_diffadr_wconf", {30'd0, wconf_a}, 32'd0);
        rd_check("t2f0", 0, 5'd10, 8'h11);
        rd_check("t2f1", 1, 5'd11, 8'h22);

        // same-address read and write in one cycle
        wr(0, 5'd5, 8'h11, 8'h00); cyc(); idle();
        wr(0, 5'd5, 8'h22, 8'h00); re[0] = 1'b1; radr[4:0] = 5'd5; cyc(); idle();
        check("t3_a_old", {24'd0, q_a[7:0]}, 32'h11);
        check("t3_a_qv", {30'd0, qv_a}, 32'd1);
        check("t3_b_qv0", {30'd0, qv_b}, 32'd0);
        cyc();
        check("t3_b_new", {24'd0, q_b[7:0]}, 32'h22);
        check("t3_b_qv", {30'd0, qv_b}, 32'd1);
        rd_check("t3_after", 0, 5'd5, 8'h22);

        // deep sleep for three cycles, then wake
        ds = 1'b1; cyc();
        check_rdy("t4_ds0", 1'b0);
        check("t4_ds0_qa", {16'd0, q_a}, 32'd0);
        check("t4_ds0_qb", {16'd0, q_b}, 32'd0);
        cyc();
        check_rdy("t4_ds1", 1'b0);
        wr(0, 5'd5, 8'hEE, 8'h00); cyc(); idle();
        check("t4_ds2_drop", {31'd0, drop_a}, 32'd1);
        check_rdy("t4_ds2", 1'b0);
        ds = 1'b0; cyc();
        check_rdy("t4_w1", 1'b0);
        check("t4_w1_drop", {31'd0, drop_a}, 32'd0);
        check("t4_w1_qa", {16'd0, q_a}, 32'd0);
        re[0] = 1'b1; radr[4:0] = 5'd5; cyc(); idle();
        check_rdy("t4_w2", 1'b0);
        check("t4_w2_drop_a", {31'd0, drop_a}, 32'd1);
        check("t4_w2_drop_b", {31'd0, drop_b}, 32'd1);
        check("t4_w2_qv", {30'd0, qv_a}, 32'd0);
        cyc();
        check_rdy("t4_w3", 1'b0);
        check("t4_w3_qvb", {30'd0, qv_b}, 32'd0);
        cyc();
        check_rdy("t4_w4", 1'b0);
        cyc();
        check_rdy("t4_act", 1'b1);
        check("t4_hold_qa", {24'd0, q_a[7:0]}, 32'h22);
        rd_check("t4_keep5", 0, 5'd5, 8'h22);
        rd_check("t4_keep9", 1, 5'd9, 8'h3C);

        // light sleep flushes the two-stage read pipe
        re[0] = 1'b1; radr[4:0] = 5'd3; cyc(); idle();
        check("t5_a_q", {24'd0, q_a[7:0]}, 32'hA5);
        check("t5_a_qv", {30'd0, qv_a}, 32'd1);
        ls = 1'b1; cyc();
        check_rdy("t5_ls1", 1'b0);
        check("t5_b_flush", {30'd0, qv_b}, 32'd0);
        check("t5_b_hold", {24'd0, q_b[7:0]}, 32'h22);
        check("t5_a_hold", {24'd0, q_a[7:0]}, 32'hA5);
        cyc();
        check_rdy("t5_ls2", 1'b0);
        ls = 1'b0; cyc();
        check_rdy("t5_back", 1'b1);
        check("t5_b_nolate", {30'd0, qv_b}, 32'd0);

        // ds outranks ls: sleep is deep (q forced 0) and wake takes WAKE_CYC cycles
        ds = 1'b1; ls = 1'b1; cyc();
        check("prio_q_zero", {16'd0, q_a}, 32'd0);
        ds = 1'b0; ls = 1'b0;
        n = 0;
        while (!rdy_a && n < 20) begin
            cyc();
            n++;
        end
        check("prio_wake_len", n, 32'd5);

        // shutdown, then reset in the middle of WAKE
        sd = 1'b1; cyc();
        check_rdy("t6_sd", 1'b0);
        check("t6_sd_qb", {16'd0, q_b}, 32'd0);
        sd = 1'b0; cyc(); cyc();
        check_rdy("t6_wake", 1'b0);
        rst = 1'b1; cyc(); rst = 1'b0;
        check_rdy("t6_rst", 1'b1);
        check("t6_rst_qa", {16'd0, q_a}, 32'd0);
        check("t6_rst_qvb", {30'd0, qv_b}, 32'd0);
        re[0] = 1'b1; radr[4:0] = 5'd7; cyc(); idle();
        check("t6_xread_qva", {30'd0, qv_a}, 32'd1);
        cyc();
        check("t6_xread_qvb", {30'd0, qv_b}, 32'd1);
        wr(0, 5'd7, 8'h5A, 8'h00); cyc(); idle();
        rd_check("t6_rewrite", 0, 5'd7, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
